// File: rtl/sw_target_feeder.sv
// Target-symbol feeder for the Smith-Waterman T/V/F feedback buffer: loads a 2-bit
// base sequence over a valid/ready port, then sweeps count 1..2*SEQ_LEN downstream.
module sw_target_feeder #(
    parameter int PE_NUM  = 128,
    parameter int SEQ_LEN = 2 * PE_NUM,
    parameter int CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_data,
    input  logic             wr_last,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       data_t_o
);

    localparam int ADR_W = $clog2(SEQ_LEN);
    localparam int PTR_W = ADR_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(SEQ_LEN);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SEQ_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_LOADED = 2'b10,
        ST_STREAM = 2'b11
    } state_t;

    logic [1:0]       mem_q [SEQ_LEN];
    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [1:0]       data_q, data_d;
    logic             wr_en_s;
    logic [ADR_W-1:0] rd_addr_s;

    // Write acceptance is a pure decode so the loader sees backpressure in the same cycle.
    assign wr_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && (wr_ptr_q < PTR_FULL);

    // Next-state, pointer and registered-output computation.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        count_d   = count_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        data_d    = data_q;
        wr_en_s   = 1'b0;
        rd_addr_s = count_q[ADR_W-1:0];
        if (clr) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            len_d    = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            data_d   = 2'b00;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (wr_valid && wr_ready) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        state_d  = ST_LOAD;
                        if (wr_last || (wr_ptr_q == PTR_LAST)) begin
                            len_d   = wr_ptr_q + PTR_W'(1);
                            state_d = ST_LOADED;
                        end else begin
                            len_d = len_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LOADED: begin
                    if (start) begin
                        state_d = ST_STREAM;
                        valid_d = 1'b1;
                        count_d = CNT_W'(1);
                        data_d  = mem_q[0];
                    end else begin
                        state_d = ST_LOADED;
                    end
                end
                ST_STREAM: begin
                    if (count_q == CNT_MAX) begin
                        state_d = ST_LOADED;
                        valid_d = 1'b0;
                        count_d = '0;
                        data_d  = 2'b00;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        valid_d = 1'b1;
                        // count_q is the zero-based index of the next symbol; past len it pads with 0.
                        if (count_q < CNT_W'(len_q)) begin
                            data_d = mem_q[rd_addr_s];
                        end else begin
                            data_d = 2'b00;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                    len_d    = '0;
                    count_d  = '0;
                    valid_d  = 1'b0;
                    data_d   = 2'b00;
                end
            endcase
        end
        busy_d = (state_d == ST_STREAM);
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
        end
    end

    // Symbol storage; contents survive reset and clear, only the length is dropped.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[ADR_W-1:0]] <= wr_data;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign valid    = valid_q;
    assign count    = count_q;
    assign data_t_o = data_q;

endmodule

// File: tb/tb_sw_target_feeder.sv
// Randomized self-checking bench for sw_target_feeder; expected streams come from a
// queue of loaded symbols and the count/pad rule.
module tb_sw_target_feeder;

    localparam int SEQ_LEN = 256;
    localparam int CNT_W   = 12;
    localparam int STREAM_LEN = 2 * SEQ_LEN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             clr = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [1:0]       wr_data = 2'b00;
    logic             wr_last = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic [1:0]       data_t_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] seq_q [$];
    logic [1:0] fix5 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    sw_target_feeder #(.PE_NUM(128), .SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .count    (count),
        .data_t_o (data_t_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input logic exp_ready);
        chk({tag, ".valid"}, valid, 0);
        chk({tag, ".count"}, count, 0);
        chk({tag, ".data"}, data_t_o, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".wr_ready"}, wr_ready, exp_ready);
    endtask

    // mode 0: i%4, mode 1: fixed five-symbol pattern, mode 2: random
    task automatic load_seq(input int n, input int mode, input bit last_on_n,
                            input bit gaps, input bit start_on_last);
        logic [1:0] d;
        seq_q.delete();
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                wr_valid = 1'b0;
                wr_data  = 2'($urandom);
                tick();
            end
            case (mode)
                0:       d = 2'(i % 4);
                1:       d = fix5[i];
                default: d = 2'($urandom);
            endcase
            chk("load.wr_ready", wr_ready, 1);
            wr_valid = 1'b1;
            wr_data  = d;
            wr_last  = last_on_n && (i == n - 1);
            start    = start_on_last && (i == n - 1);
            seq_q.push_back(d);
            tick();
            wr_valid = 1'b0;
            wr_last  = 1'b0;
            start    = 1'b0;
        end
        chk("loaded.wr_ready", wr_ready, 0);
        chk("loaded.valid", valid, 0);
        chk("loaded.busy", busy, 0);
    endtask

    task automatic garbage_writes(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            wr_valid = 1'b1;
            wr_data  = 2'($urandom);
            wr_last  = 1'($urandom);
            chk("garbage.wr_ready", wr_ready, 0);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // start_k: count at which a stray start is driven; abort_k: count at which rst_n drops
    task automatic run_stream(input int start_k, input int abort_k);
        logic [1:0] exp_d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= STREAM_LEN; k++) begin
            exp_d = (k <= seq_q.size()) ? seq_q[k-1] : 2'b00;
            chk("stream.valid", valid, 1);
            chk("stream.count", count, k);
            chk("stream.data", data_t_o, exp_d);
            chk("stream.busy", busy, 1);
            chk("stream.done", done, 0);
            if (k == abort_k) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_quiet("async_rst", 1'b1);
                #2;
                rst_n = 1'b1;
                tick();
                chk_quiet("post_rst", 1'b1);
                return;
            end
            if (k == start_k) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("end.valid", valid, 0);
        chk("end.count", count, 0);
        chk("end.data", data_t_o, 0);
        chk("end.done", done, 1);
        chk("end.busy", busy, 0);
        chk("end.wr_ready", wr_ready, 0);
        tick();
        chk("after.done", done, 0);
        for (int i = 0; i < 3; i++) begin
            chk("after.valid", valid, 0);
            chk("after.count", count, 0);
            tick();
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_quiet("clr", 1'b1);
    endtask

    initial begin
        int n;
        bit lst;
        #1 rst_n = 1'b0;
        #1;
        chk_quiet("reset", 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_quiet("reset_rel", 1'b1);

        // start in IDLE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_quiet("idle_start", 1'b1);

        // full i%4 load with start on the final write, then two identical runs
        load_seq(SEQ_LEN, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("no_early_stream", valid, 0);
        run_stream(0, 0);
        run_stream(0, 0);

        // five-symbol load; stray start at count 100
        do_clr();
        load_seq(5, 1, 1'b1, 1'b0, 1'b0);
        garbage_writes(3);
        run_stream(100, 0);

        // clr beats start in LOADED
        clr   = 1'b1;
        start = 1'b1;
        tick();
        clr   = 1'b0;
        start = 1'b0;
        chk_quiet("clr_start", 1'b1);
        tick();
        chk_quiet("clr_start2", 1'b1);

        // 256 writes without wr_last still terminate the load; reset at count 300
        load_seq(SEQ_LEN, 2, 1'b0, 1'b1, 1'b0);
        run_stream(0, 300);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_quiet("start_no_reload", 1'b1);
            tick();
        end

        // randomized lengths, data and write gaps
        for (int it = 0; it < 4; it++) begin
            do_clr();
            n   = $urandom_range(1, SEQ_LEN);
            lst = (n < SEQ_LEN) ? 1'b1 : 1'($urandom);
            load_seq(n, 2, lst, 1'b1, 1'($urandom));
            garbage_writes($urandom_range(0, 3));
            run_stream(0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
